sdr_lb_arbiter: RTL and testbench
=================================

Name: sdr_lb_arbiter

Overview:
- Round-robin arbiter that shares one SDR controller local-bus port between NUM_PORTS requesters (e.g. AHB slave, DMA, video fetch).
- Latches the winning request, presents it to the controller, and routes RW_ACK, D_REQ, W_VALID and R_VALID back to the owner.
- Holds ownership until the burst's data phase finishes.
- Sits directly above the SDR controller top level inside the SDRAM subsystem.

Parameters:
- NUM_PORTS, 2, number of requesters (2..8)
- SDRAM_RASIZE, 31, local-bus address width
- TIMEOUT, 1023, maximum idle cycles between data beats before abort (10-bit counter)

Ports:
- CLK  in  1  system clock
- RESET_N  in  1  asynchronous active-low reset
- M_RADDR  in  NUM_PORTS*SDRAM_RASIZE  per-port address, port i at bits [i*RASIZE +: RASIZE]
- M_R_REQ  in  NUM_PORTS  per-port read request
- M_W_REQ  in  NUM_PORTS  per-port write request
- M_B_SIZE  in  NUM_PORTS*4  per-port burst size
- M_AUTO_PCH  in  NUM_PORTS  per-port autoprecharge
- M_RW_ACK  out  NUM_PORTS  routed request acknowledge
- M_D_REQ  out  NUM_PORTS  routed write-data request
- M_W_VALID  out  NUM_PORTS  routed write-data valid
- M_R_VALID  out  NUM_PORTS  routed read-data valid
- RADDR  out  SDRAM_RASIZE  to controller
- R_REQ  out  1  to controller
- W_REQ  out  1  to controller
- B_SIZE  out  4  to controller
- AUTO_PCH  out  1  to controller
- RW_ACK  in  1  from controller
- D_REQ  in  1  from controller
- W_VALID  in  1  from controller
- R_VALID  in  1  from controller
- GRANT  out  NUM_PORTS  one-hot current owner; zero when idle
- BUSY  out  1  a transaction is in progress
- TO_ERR  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset: all outputs 0, state IDLE, round-robin pointer last=NUM_PORTS-1 (port 0 highest priority first), counters 0.
- States:
  - IDLE -> REQ when any M_R_REQ|M_W_REQ bit is high.
  - REQ -> DATA on RW_ACK.
  - DATA -> IDLE when the beat count is reached or on timeout.
- Arbitration in IDLE: search ports last+1, last+2, ... modulo NUM_PORTS. The first port with a request wins.
- On the winning clock edge:
  - register winner into GRANT and last;
  - latch RADDR, B_SIZE, AUTO_PCH, direction.
  - Controller request output goes high the cycle after the request is first sampled (1-cycle latency).
- Direction: if a port asserts both M_W_REQ and M_R_REQ, the transaction is a write. The read stays pending for a later grant.
- R_REQ/W_REQ are the registered request AND NOT RW_ACK. The request drops combinationally in the ack cycle, so the controller never sees a duplicate.
- Requesters must hold their request until M_RW_ACK. A request dropped after the grant edge has no effect: the latched transaction completes.
- Routing: M_x[i] = x & GRANT[i] for RW_ACK, D_REQ, W_VALID, R_VALID. Non-owners always see 0.
- Beat count:
  - beats = B_SIZE latched, with 0 meaning 16.
  - A write counts W_VALID; a read counts R_VALID.
  - Counting is active in both REQ and DATA (a beat coincident with RW_ACK is counted).
- Completion: in the cycle the count reaches beats, the next state is IDLE and GRANT clears. Arbitration restarts in the following cycle, so there is a minimum 1 idle cycle between transactions.
- Timeout:
  - In DATA, a 10-bit counter increments each cycle without a counted beat and clears on a beat.
  - When it reaches TIMEOUT: return to IDLE, pulse TO_ERR for 1 cycle, clear GRANT.
  - REQ has no timeout, because controller init/refresh may stall the ack indefinitely.
- Stray beats (R_VALID/W_VALID in IDLE, or of the wrong direction) are ignored and not routed to any port.
- BUSY = state != IDLE.
- Asynchronous reset mid-transaction returns everything to reset values immediately. The controller must be reset together with the arbiter.

Test Plan:
- Port 0 write, B_SIZE=4, controller acks at cycle 5 and gives W_VALID on 4 cycles -> W_REQ high cycles 2..4 and low at ack. M_W_VALID[0] pulses 4 times, M_W_VALID[1]=0. GRANT returns to 0 after the 4th beat.
- Ports 0 and 1 request reads simultaneously and continuously, B_SIZE=2 -> grants alternate 0,1,0,1. Each grant has exactly 2 routed R_VALID beats.
- Port 1 asserts R_REQ and W_REQ with B_SIZE=0 -> write of 16 beats. After completion the read is granted next if port 0 is idle.
- RW_ACK coincident with the first R_VALID, B_SIZE=1 -> transaction completes in the ack cycle and BUSY deasserts the next cycle.
- TIMEOUT=8 with the controller stalling after 1 of 4 beats -> TO_ERR pulses once 8 cycles after the last beat, and GRANT clears.
- RESET_N asserted in DATA mid-burst -> all outputs 0 immediately. After release, port 0 wins first over a simultaneous port 1 request.

Source files
------------

// File: rtl/sdr_lb_arbiter_if.sv
// ----------------------------------------------------------------------------
// sdr_lb_arbiter_if
//   Bundles the requester-side and controller-side signals of the SDR
//   local-bus arbiter.
//   slave  : the arbiter's view. It receives the per-port requests and the
//            controller handshakes, and it drives the routed handshakes, the
//            controller request and the status outputs.
//   master : the environment's view (requesters plus controller), with every
//            direction reversed.
//   Per-port vectors: port i uses M_RADDR[i*SDRAM_RASIZE +: SDRAM_RASIZE],
//   M_B_SIZE[i*4 +: 4], and bit i of every other M_* vector.
// ----------------------------------------------------------------------------
interface sdr_lb_arbiter_if #(
    parameter int NUM_PORTS    = 2,
    parameter int SDRAM_RASIZE = 31
);
    // requester side
    logic [NUM_PORTS*SDRAM_RASIZE-1:0] M_RADDR;
    logic [NUM_PORTS-1:0]              M_R_REQ;
    logic [NUM_PORTS-1:0]              M_W_REQ;
    logic [NUM_PORTS*4-1:0]            M_B_SIZE;
    logic [NUM_PORTS-1:0]              M_AUTO_PCH;
    logic [NUM_PORTS-1:0]              M_RW_ACK;
    logic [NUM_PORTS-1:0]              M_D_REQ;
    logic [NUM_PORTS-1:0]              M_W_VALID;
    logic [NUM_PORTS-1:0]              M_R_VALID;
    // controller side
    logic [SDRAM_RASIZE-1:0]           RADDR;
    logic                              R_REQ;
    logic                              W_REQ;
    logic [3:0]                        B_SIZE;
    logic                              AUTO_PCH;
    logic                              RW_ACK;
    logic                              D_REQ;
    logic                              W_VALID;
    logic                              R_VALID;
    // status
    logic [NUM_PORTS-1:0]              GRANT;
    logic                              BUSY;
    logic                              TO_ERR;

    modport slave (
        input  M_RADDR, M_R_REQ, M_W_REQ, M_B_SIZE, M_AUTO_PCH,
        input  RW_ACK, D_REQ, W_VALID, R_VALID,
        output M_RW_ACK, M_D_REQ, M_W_VALID, M_R_VALID,
        output RADDR, R_REQ, W_REQ, B_SIZE, AUTO_PCH,
        output GRANT, BUSY, TO_ERR
    );

    modport master (
        output M_RADDR, M_R_REQ, M_W_REQ, M_B_SIZE, M_AUTO_PCH,
        output RW_ACK, D_REQ, W_VALID, R_VALID,
        input  M_RW_ACK, M_D_REQ, M_W_VALID, M_R_VALID,
        input  RADDR, R_REQ, W_REQ, B_SIZE, AUTO_PCH,
        input  GRANT, BUSY, TO_ERR
    );
endinterface

// File: rtl/sdr_lb_arbiter.sv
// ----------------------------------------------------------------------------
// sdr_lb_arbiter
//   Round-robin arbiter that shares one SDR controller local-bus port among
//   NUM_PORTS requesters. It latches the winning request, presents it to the
//   controller, and routes the ack and data strobes back to the owner until
//   that owner's burst completes or times out.
// Ports:
//   CLK     : system clock
//   RESET_N : asynchronous active-low reset
//   bus     : sdr_lb_arbiter_if.slave. Carries the per-port requests and the
//             routed strobes, the controller request/handshake, and the
//             GRANT / BUSY / TO_ERR status outputs.
// ----------------------------------------------------------------------------
module sdr_lb_arbiter #(
    parameter int NUM_PORTS    = 2,
    parameter int SDRAM_RASIZE = 31,
    parameter int TIMEOUT      = 1023
) (
    input  logic                CLK,
    input  logic                RESET_N,
    sdr_lb_arbiter_if.slave     bus
);

    localparam int              LW       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [9:0]      TO_LIMIT = 10'(TIMEOUT);
    localparam logic [LW-1:0]   LAST_RST = LW'(NUM_PORTS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t                  state_q;
    logic [NUM_PORTS-1:0]    grant_q;
    logic [LW-1:0]           last_q;
    logic [SDRAM_RASIZE-1:0] raddr_q;
    logic [3:0]              bsize_q;
    logic                    pch_q;
    logic                    wr_q;
    logic                    req_q;
    logic [4:0]              beat_cnt_q;
    logic [4:0]              beat_cnt_d;
    logic [9:0]              to_cnt_q;
    logic [9:0]              to_cnt_d;
    logic                    to_err_q;

    logic [NUM_PORTS-1:0]    req_any_s;
    logic [NUM_PORTS-1:0]    win_oh_s;
    logic [LW-1:0]           win_idx_s;
    logic                    win_vld_s;
    int                      cand_s;
    logic [4:0]              beats_s;
    logic                    beat_s;
    logic                    reached_s;
    logic                    to_hit_s;

    // Round-robin search starting one past the last owner.
    always_comb begin
        req_any_s = bus.M_R_REQ | bus.M_W_REQ;
        win_idx_s = '0;
        win_vld_s = 1'b0;
        cand_s    = 0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            cand_s    = (int'(last_q) + k) % NUM_PORTS;
            win_idx_s = (!win_vld_s && req_any_s[cand_s]) ? LW'(cand_s) : win_idx_s;
            win_vld_s = win_vld_s | req_any_s[cand_s];
        end
        win_oh_s            = '0;
        win_oh_s[win_idx_s] = win_vld_s;
    end

    // Beat counting and the data-phase inactivity counter.
    always_comb begin
        // A B_SIZE of 0 encodes a 16-beat burst.
        beats_s    = (bsize_q == 4'd0) ? 5'd16 : {1'b0, bsize_q};
        // Only beats in the latched direction count. Stray beats are ignored.
        beat_s     = (state_q != ST_IDLE) & (wr_q ? bus.W_VALID : bus.R_VALID);
        beat_cnt_d = beat_cnt_q + {4'd0, beat_s};
        reached_s  = (beat_cnt_d >= beats_s);
        to_cnt_d   = beat_s ? 10'd0 : (to_cnt_q + 10'd1);
        to_hit_s   = (state_q == ST_DATA) & ~beat_s & (to_cnt_d == TO_LIMIT);
    end

    // Transaction FSM: arbitration, request latching, completion and timeout.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            last_q     <= LAST_RST;
            raddr_q    <= '0;
            bsize_q    <= 4'd0;
            pch_q      <= 1'b0;
            wr_q       <= 1'b0;
            req_q      <= 1'b0;
            beat_cnt_q <= 5'd0;
            to_cnt_q   <= 10'd0;
            to_err_q   <= 1'b0;
        end else begin
            to_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    beat_cnt_q <= 5'd0;
                    to_cnt_q   <= 10'd0;
                    if (win_vld_s) begin
                        state_q <= ST_REQ;
                        grant_q <= win_oh_s;
                        last_q  <= win_idx_s;
                        raddr_q <= bus.M_RADDR[win_idx_s*SDRAM_RASIZE +: SDRAM_RASIZE];
                        bsize_q <= bus.M_B_SIZE[win_idx_s*4 +: 4];
                        pch_q   <= bus.M_AUTO_PCH[win_idx_s];
                        // A simultaneous read request stays pending for a later grant.
                        wr_q    <= bus.M_W_REQ[win_idx_s];
                        req_q   <= 1'b1;
                    end
                end
                ST_REQ: begin
                    // No timeout here: init/refresh may hold off the ack indefinitely.
                    beat_cnt_q <= beat_cnt_d;
                    to_cnt_q   <= 10'd0;
                    if (bus.RW_ACK) begin
                        req_q <= 1'b0;
                        if (reached_s) begin
                            state_q <= ST_IDLE;
                            grant_q <= '0;
                        end else begin
                            state_q <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    beat_cnt_q <= beat_cnt_d;
                    to_cnt_q   <= to_cnt_d;
                    if (reached_s) begin
                        state_q <= ST_IDLE;
                        grant_q <= '0;
                    end else if (to_hit_s) begin
                        state_q  <= ST_IDLE;
                        grant_q  <= '0;
                        to_err_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    grant_q <= '0;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    // The request drops in the ack cycle itself, so the controller never sees a second request.
    assign bus.R_REQ    = req_q & ~wr_q & ~bus.RW_ACK;
    assign bus.W_REQ    = req_q &  wr_q & ~bus.RW_ACK;
    assign bus.RADDR    = raddr_q;
    assign bus.B_SIZE   = bsize_q;
    assign bus.AUTO_PCH = pch_q;

    // Non-owners always see 0. Valids of the wrong direction are not routed.
    assign bus.M_RW_ACK  = grant_q & {NUM_PORTS{bus.RW_ACK}};
    assign bus.M_D_REQ   = grant_q & {NUM_PORTS{bus.D_REQ}};
    assign bus.M_W_VALID = grant_q & {NUM_PORTS{bus.W_VALID &  wr_q}};
    assign bus.M_R_VALID = grant_q & {NUM_PORTS{bus.R_VALID & ~wr_q}};

    assign bus.GRANT  = grant_q;
    assign bus.BUSY   = (state_q != ST_IDLE);
    assign bus.TO_ERR = to_err_q;

endmodule

// File: tb/tb_sdr_lb_arbiter.sv
// ----------------------------------------------------------------------------
// tb_sdr_lb_arbiter
//   Directed bench for sdr_lb_arbiter (2 ports, TIMEOUT=8). The bench plays
//   both the requesters and the controller. Inputs change 2 time units after
//   each rising edge, and outputs are sampled there or 1 unit later.
// ----------------------------------------------------------------------------
module tb_sdr_lb_arbiter;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    logic [4:0] pat;

    sdr_lb_arbiter_if #(.NUM_PORTS(2), .SDRAM_RASIZE(31)) bus_if ();

    sdr_lb_arbiter #(.NUM_PORTS(2), .SDRAM_RASIZE(31), .TIMEOUT(8)) dut (
        .CLK     (clk),
        .RESET_N (rst_n),
        .bus     (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus_if.M_RADDR    = '0;
        bus_if.M_R_REQ    = 2'b00;
        bus_if.M_W_REQ    = 2'b00;
        bus_if.M_B_SIZE   = 8'h00;
        bus_if.M_AUTO_PCH = 2'b00;
        bus_if.RW_ACK     = 1'b0;
        bus_if.D_REQ      = 1'b0;
        bus_if.W_VALID    = 1'b0;
        bus_if.R_VALID    = 1'b0;

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #2;
        chk("rst_grant", bus_if.GRANT, 2'b00);
        chk("rst_busy", bus_if.BUSY, 1'b0);
        chk("rst_req", {bus_if.R_REQ, bus_if.W_REQ}, 2'b00);
        chk("rst_to_err", bus_if.TO_ERR, 1'b0);
        #1 rst_n = 1'b1;
        cyc();
        chk("idle_grant", bus_if.GRANT, 2'b00);

        // ---- T1: port 0 write, 4 beats ----
        bus_if.M_RADDR[30:0] = 31'h0123_4567;
        bus_if.M_B_SIZE[3:0] = 4'd4;
        bus_if.M_AUTO_PCH    = 2'b01;
        bus_if.M_W_REQ       = 2'b01;
        cyc();
        chk("t1_grant", bus_if.GRANT, 2'b01);
        chk("t1_raddr", bus_if.RADDR, 31'h0123_4567);
        chk("t1_bsize", bus_if.B_SIZE, 4'd4);
        chk("t1_pch", bus_if.AUTO_PCH, 1'b1);
        chk("t1_rreq", bus_if.R_REQ, 1'b0);
        chk("t1_busy", bus_if.BUSY, 1'b1);
        for (int k = 0; k < 3; k++) begin
            chk("t1_wreq_hi", bus_if.W_REQ, 1'b1);
            cyc();
        end
        bus_if.RW_ACK = 1'b1;
        #1;
        chk("t1_wreq_ack", bus_if.W_REQ, 1'b0);
        chk("t1_rw_ack", bus_if.M_RW_ACK, 2'b01);
        cyc();
        bus_if.RW_ACK  = 1'b0;
        bus_if.M_W_REQ = 2'b00;
        // four beats with a gap at slot 2, plus a stray read strobe at slot 1
        pat = 5'b11011;
        for (int i = 0; i < 5; i++) begin
            bus_if.W_VALID = pat[i];
            bus_if.R_VALID = (i == 1);
            bus_if.D_REQ   = (i == 2);
            #1;
            chk("t1_wvalid", bus_if.M_W_VALID, {1'b0, pat[i]});
            chk("t1_stray_r", bus_if.M_R_VALID, 2'b00);
            if (i == 2) chk("t1_dreq", bus_if.M_D_REQ, 2'b01);
            cyc();
            chk("t1_own", bus_if.GRANT, (i == 4) ? 2'b00 : 2'b01);
        end
        bus_if.W_VALID = 1'b0;
        bus_if.R_VALID = 1'b0;
        bus_if.D_REQ   = 1'b0;
        chk("t1_busy_end", bus_if.BUSY, 1'b0);

        // ---- T2: both ports read continuously; last owner was 0 so port 1 leads ----
        bus_if.M_B_SIZE = 8'h22;
        bus_if.M_R_REQ  = 2'b11;
        cyc();
        for (int t = 0; t < 4; t++) begin
            logic [1:0] eg;
            eg = (t % 2 == 0) ? 2'b10 : 2'b01;
            chk("t2_grant", bus_if.GRANT, eg);
            chk("t2_rreq", bus_if.R_REQ, 1'b1);
            bus_if.RW_ACK = 1'b1;
            #1;
            chk("t2_rreq_ack", bus_if.R_REQ, 1'b0);
            chk("t2_rw_ack", bus_if.M_RW_ACK, eg);
            if (t == 3) bus_if.M_R_REQ = 2'b00;
            cyc();
            bus_if.RW_ACK = 1'b0;
            for (int b = 0; b < 2; b++) begin
                bus_if.R_VALID = 1'b1;
                #1;
                chk("t2_rvalid", bus_if.M_R_VALID, eg);
                cyc();
            end
            bus_if.R_VALID = 1'b0;
            chk("t2_gap", bus_if.GRANT, 2'b00);
            cyc();
        end
        chk("t2_idle", bus_if.BUSY, 1'b0);

        // ---- T3: port 1 asserts both read and write, B_SIZE=0 -> 16-beat write ----
        bus_if.M_RADDR[61:31] = 31'h2AAA_5555;
        bus_if.M_B_SIZE       = 8'h02;
        bus_if.M_R_REQ        = 2'b10;
        bus_if.M_W_REQ        = 2'b10;
        cyc();
        chk("t3_grant", bus_if.GRANT, 2'b10);
        chk("t3_wreq", bus_if.W_REQ, 1'b1);
        chk("t3_rreq", bus_if.R_REQ, 1'b0);
        chk("t3_bsize", bus_if.B_SIZE, 4'd0);
        chk("t3_raddr", bus_if.RADDR, 31'h2AAA_5555);
        bus_if.RW_ACK = 1'b1;
        #1;
        chk("t3_wreq_ack", bus_if.W_REQ, 1'b0);
        bus_if.M_W_REQ  = 2'b00;
        bus_if.M_B_SIZE = 8'h12;
        cyc();
        bus_if.RW_ACK = 1'b0;
        for (int b = 0; b < 16; b++) begin
            bus_if.W_VALID = 1'b1;
            #1;
            chk("t3_wvalid", bus_if.M_W_VALID, 2'b10);
            cyc();
            chk("t3_own", bus_if.GRANT, (b == 15) ? 2'b00 : 2'b10);
        end
        bus_if.W_VALID = 1'b0;
        cyc();
        chk("t3_rd_grant", bus_if.GRANT, 2'b10);
        chk("t3_rd_rreq", bus_if.R_REQ, 1'b1);
        chk("t3_rd_bsize", bus_if.B_SIZE, 4'd1);

        // ---- T4: ack coincident with the only beat ----
        bus_if.RW_ACK  = 1'b1;
        bus_if.R_VALID = 1'b1;
        #1;
        chk("t4_rreq_ack", bus_if.R_REQ, 1'b0);
        chk("t4_rvalid", bus_if.M_R_VALID, 2'b10);
        chk("t4_rw_ack", bus_if.M_RW_ACK, 2'b10);
        bus_if.M_R_REQ = 2'b00;
        cyc();
        bus_if.RW_ACK  = 1'b0;
        bus_if.R_VALID = 1'b0;
        chk("t4_busy", bus_if.BUSY, 1'b0);
        chk("t4_grant", bus_if.GRANT, 2'b00);

        // ---- stray strobes while idle ----
        bus_if.W_VALID = 1'b1;
        bus_if.R_VALID = 1'b1;
        #1;
        chk("stray_w", bus_if.M_W_VALID, 2'b00);
        chk("stray_r", bus_if.M_R_VALID, 2'b00);
        cyc();
        bus_if.W_VALID = 1'b0;
        bus_if.R_VALID = 1'b0;
        chk("stray_busy", bus_if.BUSY, 1'b0);

        // ---- T5: a long ack stall in REQ, then timeout 8 cycles after the last beat ----
        bus_if.M_B_SIZE = 8'h14;
        bus_if.M_W_REQ  = 2'b01;
        cyc();
        chk("t5_grant", bus_if.GRANT, 2'b01);
        repeat (12) cyc();
        chk("t5_req_stall", bus_if.GRANT, 2'b01);
        chk("t5_req_noerr", bus_if.TO_ERR, 1'b0);
        bus_if.RW_ACK  = 1'b1;
        bus_if.M_W_REQ = 2'b00;
        cyc();
        bus_if.RW_ACK  = 1'b0;
        bus_if.W_VALID = 1'b1;
        cyc();
        bus_if.W_VALID = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            chk("t5_wait_err", bus_if.TO_ERR, 1'b0);
            chk("t5_wait_own", bus_if.GRANT, 2'b01);
            cyc();
        end
        chk("t5_to_err", bus_if.TO_ERR, 1'b1);
        chk("t5_grant_clr", bus_if.GRANT, 2'b00);
        chk("t5_busy", bus_if.BUSY, 1'b0);
        cyc();
        chk("t5_pulse_end", bus_if.TO_ERR, 1'b0);

        // ---- T6: asynchronous reset mid-burst ----
        bus_if.M_R_REQ = 2'b01;
        cyc();
        chk("t6_grant", bus_if.GRANT, 2'b01);
        bus_if.RW_ACK  = 1'b1;
        bus_if.M_R_REQ = 2'b00;
        cyc();
        bus_if.RW_ACK  = 1'b0;
        bus_if.R_VALID = 1'b1;
        cyc();
        bus_if.R_VALID = 1'b0;
        chk("t6_busy_pre", bus_if.BUSY, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_grant", bus_if.GRANT, 2'b00);
        chk("t6_rst_busy", bus_if.BUSY, 1'b0);
        chk("t6_rst_raddr", bus_if.RADDR, 31'h0);
        chk("t6_rst_bsize", bus_if.B_SIZE, 4'd0);
        bus_if.M_R_REQ = 2'b11;
        #3 rst_n = 1'b1;
        cyc();
        chk("t6_post_grant", bus_if.GRANT, 2'b01);
        chk("t6_post_rreq", bus_if.R_REQ, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
